// File: rtl/traffic_phase_sched_pkg.sv
// Shared state encodings, lamp patterns and default dwell values for the intersection scheduler.
// Optional night-flash build: TRAFFIC_NIGHT_FLASH_EN.
package traffic_pkg;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6,
        NF  = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int DEF_CW       = 4;
    localparam int DEF_MIN_GRN  = 8;
    localparam int DEF_SIDE_GRN = 6;
    localparam int DEF_YEL      = 3;
    localparam int DEF_ALLRED   = 1;
    localparam int DEF_WALK     = 5;

    // Counter value on the final tick of a dwell; a zero dwell acts like one tick.
    function automatic int dwellLast(input int n);
        return (n <= 1) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// Request/lamp bus between the board and the phase scheduler.
// The night input exists only when TRAFFIC_NIGHT_FLASH_EN is defined.
interface traffic_phase_sched_if;
    logic       tick;
    logic       side_req;
    logic       ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic       night;
`endif
    logic [5:0] lights;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    modport master (output tick, side_req, ped_req, night, input lights, walk, ped_ack, phase);
    modport slave  (input tick, side_req, ped_req, night, output lights, walk, ped_ack, phase);
`else
    modport master (output tick, side_req, ped_req, input lights, walk, ped_ack, phase);
    modport slave  (input tick, side_req, ped_req, output lights, walk, ped_ack, phase);
`endif
endinterface

// File: rtl/traffic_phase_sched_dwell.sv
// Tick-gated dwell counter: flags the last tick of a dwell and can hold there (main-green saturation).
module traffic_dwell_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_tick,
    input  logic          i_load0,
    input  logic          i_hold,
    input  logic [CW-1:0] i_last,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;

    assign o_done = (r_cnt == i_last);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (i_load0) begin
            r_cnt <= '0;
        end else if (i_tick && !(i_hold && o_done)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// Intersection phase scheduler: main/side/pedestrian sequencing with yellow and all-red clearance.
// Define TRAFFIC_NIGHT_FLASH_EN to add the night flashing-yellow mode.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int MIN_GRN  = DEF_MIN_GRN,
    parameter int SIDE_GRN = DEF_SIDE_GRN,
    parameter int YEL      = DEF_YEL,
    parameter int ALLRED   = DEF_ALLRED,
    parameter int WALK     = DEF_WALK
) (
    input logic                  clk,
    input logic                  clr,
    traffic_phase_sched_if.slave bus
);

    localparam logic [CW-1:0] L_MG   = CW'(dwellLast(MIN_GRN));
    localparam logic [CW-1:0] L_SG   = CW'(dwellLast(SIDE_GRN));
    localparam logic [CW-1:0] L_YEL  = CW'(dwellLast(YEL));
    localparam logic [CW-1:0] L_AR   = CW'(dwellLast(ALLRED));
    localparam logic [CW-1:0] L_WALK = CW'(dwellLast(WALK));

    state_t        r_state;
    state_t        w_next;
    logic          r_sidePend;
    logic          r_pedPend;
    logic          r_pedAck;
    logic [CW-1:0] w_last;
    logic          w_done;
    logic          w_anyPend;
    logic          w_load0;
    logic [5:0]    w_lights;
    logic          w_walk;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic          r_flash;
    logic          r_nfPass;
`endif

    assign w_anyPend = r_sidePend | r_pedPend;
    assign w_load0   = (w_next != r_state);

    traffic_dwell_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .clr     (clr),
        .i_tick  (bus.tick),
        .i_load0 (w_load0),
        .i_hold  (r_state == MG),
        .i_last  (w_last),
        .o_done  (w_done)
    );

    always_comb begin
        w_last = '0;
        case (r_state)
            MG:       w_last = L_MG;
            MY, SY:   w_last = L_YEL;
            AR1, AR2: w_last = L_AR;
            SG:       w_last = L_SG;
            PW:       w_last = L_WALK;
            default:  w_last = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MG: begin
                if (bus.tick && w_done && w_anyPend) w_next = MY;
`ifdef TRAFFIC_NIGHT_FLASH_EN
                else if (bus.tick && bus.night && !w_anyPend) w_next = NF;
`endif
            end
            MY:  if (bus.tick && w_done) w_next = AR1;
            AR1: begin
                if (bus.tick && w_done) begin
                    w_next = r_sidePend ? SG : PW;
`ifdef TRAFFIC_NIGHT_FLASH_EN
                    // A night exit with nothing pending returns to main via the second clearance.
                    if (!w_anyPend && r_nfPass) w_next = AR2;
`endif
                end
            end
            SG:  if (bus.tick && w_done) w_next = SY;
            SY:  if (bus.tick && w_done) w_next = AR2;
            AR2: if (bus.tick && w_done) w_next = r_pedPend ? PW : MG;
            PW:  if (bus.tick && w_done) w_next = MG;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            NF:  if (bus.tick && (!bus.night || w_anyPend)) w_next = AR1;
`endif
            default: w_next = MG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= MG;
            r_sidePend <= 1'b0;
            r_pedPend  <= 1'b0;
            r_pedAck   <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            r_flash    <= 1'b0;
            r_nfPass   <= 1'b0;
`endif
        end else begin
            r_state    <= w_next;
            r_pedAck   <= (w_next == PW) && (r_state != PW);
            r_sidePend <= ((w_next == SG) && (r_state != SG)) ? 1'b0 : (r_sidePend | bus.side_req);
            r_pedPend  <= ((w_next == PW) && (r_state != PW)) ? 1'b0 : (r_pedPend | bus.ped_req);
`ifdef TRAFFIC_NIGHT_FLASH_EN
            if ((w_next == NF) && (r_state != NF)) r_flash <= 1'b1;
            else if ((r_state == NF) && bus.tick)  r_flash <= ~r_flash;
            if ((r_state == NF) && (w_next == AR1))     r_nfPass <= ~w_anyPend;
            else if ((r_state == AR1) && (w_next != AR1)) r_nfPass <= 1'b0;
`endif
        end
    end

    // Lamps depend only on registered state, so they change on the same edge as the phase.
    always_comb begin
        w_lights = {LAMP_RED, LAMP_RED};
        w_walk   = 1'b0;
        case (r_state)
            MG: w_lights = {LAMP_GRN, LAMP_RED};
            MY: w_lights = {LAMP_YEL, LAMP_RED};
            SG: w_lights = {LAMP_RED, LAMP_GRN};
            SY: w_lights = {LAMP_RED, LAMP_YEL};
            PW: w_walk   = 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            NF: w_lights = {(r_flash ? LAMP_YEL : LAMP_OFF), LAMP_RED};
`endif
            default: w_lights = {LAMP_RED, LAMP_RED};
        endcase
    end

    assign bus.lights  = w_lights;
    assign bus.walk    = w_walk;
    assign bus.ped_ack = r_pedAck;
    assign bus.phase   = r_state;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for traffic_phase_sched: phase-level reference model compared every clock, plus literal sequence checks.
// Night-flash scenario runs only when TRAFFIC_NIGHT_FLASH_EN is defined.
module tb_traffic_phase_sched;

    localparam int T_MIN_GRN  = 8;
    localparam int T_SIDE_GRN = 6;
    localparam int T_YEL      = 3;
    localparam int T_ALLRED   = 1;
    localparam int T_WALK     = 5;

    logic clk;
    logic clr;
    logic checkEn;
    int   nChecks;
    int   nErrors;
    int   seq[$];
    int   expSeq[$];
    int   sgTicks;
    int   walkTicks;
    int   ackCount;

    int   mPhase;
    int   mElapsed;
    bit   mSp;
    bit   mPp;
    bit   mAck;
    bit   mFlash;
    bit   mNfPass;

    traffic_phase_sched_if intf ();

    traffic_phase_sched dut (
        .clk (clk),
        .clr (clr),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int effDwell(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int nightLevel();
`ifdef TRAFFIC_NIGHT_FLASH_EN
        return int'(intf.night);
`else
        return 0;
`endif
    endfunction

    // Lamp pattern a phase must show, written as plain bit strings.
    function automatic int lampsOf(input int p, input bit flash);
        case (p)
            0: return 6'b001100;
            1: return 6'b010100;
            3: return 6'b100001;
            4: return 6'b100010;
            7: return flash ? 6'b010100 : 6'b000100;
            default: return 6'b100100;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0b, expected %0b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: ticks elapsed in the current phase against that phase's dwell.
    task automatic modelStep();
        int  nxt;
        bit  anyP;
        if (clr) begin
            mPhase = 0; mElapsed = 0; mSp = 0; mPp = 0;
            mAck = 0; mFlash = 0; mNfPass = 0;
        end else begin
            nxt  = mPhase;
            mAck = 0;
            anyP = mSp || mPp;
            if (intf.tick) begin
                mElapsed++;
                case (mPhase)
                    0: if (mElapsed >= effDwell(T_MIN_GRN) && anyP) nxt = 1;
                       else if (nightLevel() != 0 && !anyP) nxt = 7;
                    1: if (mElapsed >= effDwell(T_YEL)) nxt = 2;
                    2: if (mElapsed >= effDwell(T_ALLRED))
                           nxt = mSp ? 3 : (mPp ? 6 : (mNfPass ? 5 : 6));
                    3: if (mElapsed >= effDwell(T_SIDE_GRN)) nxt = 4;
                    4: if (mElapsed >= effDwell(T_YEL)) nxt = 5;
                    5: if (mElapsed >= effDwell(T_ALLRED)) nxt = mPp ? 6 : 0;
                    6: if (mElapsed >= effDwell(T_WALK)) nxt = 0;
                    7: if (nightLevel() == 0 || anyP) begin
                           nxt = 2;
                           mNfPass = !anyP;
                       end else begin
                           mFlash = !mFlash;
                       end
                    default: nxt = 0;
                endcase
            end
            if (nxt != mPhase) begin
                if (mPhase == 2) mNfPass = 0;
                mElapsed = 0;
                if (nxt == 7) mFlash = 1;
                if (nxt == 6) mAck = 1;
            end
            mSp = (nxt == 3 && mPhase != 3) ? 1'b0 : (mSp | intf.side_req);
            mPp = (nxt == 6 && mPhase != 6) ? 1'b0 : (mPp | intf.ped_req);
            mPhase = nxt;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (checkEn) begin
            checkOutput("phase",   int'(intf.phase),   mPhase);
            checkOutput("lights",  int'(intf.lights),  lampsOf(mPhase, mFlash));
            checkOutput("walk",    int'(intf.walk),    (mPhase == 6) ? 1 : 0);
            checkOutput("ped_ack", int'(intf.ped_ack), int'(mAck));
        end
        if (intf.ped_ack === 1'b1) ackCount++;
    end

    task automatic doReset();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        checkEn = 1'b1;
    endtask

    task automatic beginTest();
        seq.delete();
        seq.push_back(int'(intf.phase));
        sgTicks   = 0;
        walkTicks = 0;
        ackCount  = 0;
    endtask

    // One tick every 4 clocks; requests are 1-clock pulses aligned with the chosen tick.
    task automatic applyStimulus(input int n, input int sideAt, input int pedAt, input int pedAt2);
        int p;
        for (int t = 1; t <= n; t++) begin
            intf.tick     = 1'b1;
            intf.side_req = (t == sideAt);
            intf.ped_req  = (t == pedAt) || (t == pedAt2);
            @(negedge clk);
            intf.tick     = 1'b0;
            intf.side_req = 1'b0;
            intf.ped_req  = 1'b0;
            p = int'(intf.phase);
            if (p != seq[$]) seq.push_back(p);
            if (p == 3) sgTicks++;
            if (intf.walk === 1'b1) walkTicks++;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic checkSeq(input string name);
        int n;
        checkOutput({name, "_len"}, seq.size(), expSeq.size());
        n = (seq.size() < expSeq.size()) ? seq.size() : expSeq.size();
        for (int i = 0; i < n; i++) checkOutput(name, seq[i], expSeq[i]);
    endtask

    initial begin
        nChecks       = 0;
        nErrors       = 0;
        checkEn       = 1'b0;
        clr           = 1'b1;
        intf.tick     = 1'b0;
        intf.side_req = 1'b0;
        intf.ped_req  = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        intf.night    = 1'b0;
`endif

        $display("[TB] reset idle");
        doReset();
        checkOutput("rst_lights", int'(intf.lights), 6'b001100);
        checkOutput("rst_phase",  int'(intf.phase),  0);
        checkOutput("rst_walk",   int'(intf.walk),   0);
        beginTest();
        applyStimulus(40, -1, -1, -1);
        expSeq = {0};
        checkSeq("idle_seq");
        checkOutput("idle_lights", int'(intf.lights), 6'b001100);

        $display("[TB] side request");
        doReset();
        beginTest();
        applyStimulus(30, 2, -1, -1);
        expSeq = {0, 1, 2, 3, 4, 5, 0};
        checkSeq("side_seq");
        checkOutput("side_sgTicks", sgTicks, 6);
        checkOutput("side_ackCount", ackCount, 0);

        $display("[TB] pedestrian only");
        doReset();
        beginTest();
        applyStimulus(25, -1, 10, -1);
        expSeq = {0, 1, 2, 6, 0};
        checkSeq("ped_seq");
        checkOutput("ped_walkTicks", walkTicks, 5);
        checkOutput("ped_ackCount", ackCount, 1);

        $display("[TB] simultaneous requests");
        doReset();
        beginTest();
        applyStimulus(32, 1, 1, 15);
        expSeq = {0, 1, 2, 3, 4, 5, 6, 0};
        checkSeq("both_seq");
        checkOutput("both_walkTicks", walkTicks, 5);
        checkOutput("both_ackCount", ackCount, 1);

        $display("[TB] reset mid-phase");
        doReset();
        beginTest();
        applyStimulus(15, 1, 14, -1);
        checkOutput("mid_inSg", int'(intf.phase), 3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("mid_lights", int'(intf.lights), 6'b001100);
        checkOutput("mid_phase",  int'(intf.phase),  0);
        checkOutput("mid_ack",    int'(intf.ped_ack), 0);
        beginTest();
        applyStimulus(20, -1, -1, -1);
        expSeq = {0};
        checkSeq("mid_after_seq");

`ifdef TRAFFIC_NIGHT_FLASH_EN
        $display("[TB] night flash");
        doReset();
        beginTest();
        intf.night = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            applyStimulus(1, -1, -1, -1);
            checkOutput("nf_lights", int'(intf.lights), (t % 2 == 1) ? 6'b010100 : 6'b000100);
        end
        applyStimulus(1, -1, 1, -1);
        intf.night = 1'b0;
        applyStimulus(10, -1, -1, -1);
        expSeq = {0, 7, 2, 6, 0};
        checkSeq("nf_seq");
        checkOutput("nf_ackCount", ackCount, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
